// File: rtl/bcd_disp_pkg.sv
// -----------------------------------------------------------------------------
// bcd_disp_pkg
// Shared constants and the BCD-to-7-segment lookup for the scanned BCD display.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low
// (a 0 lights the segment).
// -----------------------------------------------------------------------------
package bcd_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] BCD_MAX   = 4'd9;

  // Active-low code for one BCD digit. Non-decimal codes 10..15 show blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] code;
    case (bcd)
      4'd0:    code = 7'h40;
      4'd1:    code = 7'h79;
      4'd2:    code = 7'h24;
      4'd3:    code = 7'h30;
      4'd4:    code = 7'h19;
      4'd5:    code = 7'h12;
      4'd6:    code = 7'h02;
      4'd7:    code = 7'h78;
      4'd8:    code = 7'h00;
      4'd9:    code = 7'h10;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bcd_scan_display_cell.sv
// -----------------------------------------------------------------------------
// bcd_digit_cell
// One upper decade of the cascaded BCD count. Counts 0..9 and wraps on inc;
// inc_out passes the advance to the next decade in the same cycle.
//
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset (digit -> 0)
//   clr     in   synchronous clear (digit -> 0), wins over inc
//   inc     in   advance this decade on the next edge
//   d       out  current BCD digit (0..9)
//   is9     out  digit == 9
//   inc_out out  inc & is9, advance for the next decade up
// -----------------------------------------------------------------------------
module bcd_digit_cell
  import bcd_disp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] d,
  output logic       is9,
  output logic       inc_out
);

  assign is9     = (d == BCD_MAX);
  assign inc_out = inc & is9;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, which keeps the whole cascade single-cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d <= 4'd0;
    end else if (clr) begin
      d <= 4'd0;
    end else if (inc) begin
      d <= is9 ? 4'd0 : d + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_scan_display.sv
// -----------------------------------------------------------------------------
// bcd_scan_display
// Extends a single-digit decade counter with NDIG-1 cascaded upper BCD digits
// and drives a time-multiplexed common-anode 7-segment display.
//
// Parameters:
//   NDIG      total digits including the ones digit (2..8)
//   SCAN_DIV  clk cycles per scan slot (>= 2)
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   en_in     in   count enable shared with the decade stage
//   ones_in   in   ones digit from the decade stage
//   carry_in  in   decade stage "digit == 9" level
//   clr       in   synchronous clear of upper digits and ovf
//   value_bcd out  {upper digits, ones_in}, digit k at [4k+3:4k]
//   ovf       out  sticky overflow, cleared by clr or rst
//   seg       out  {g,f,e,d,c,b,a}, active-low, registered
//   an        out  one-hot active-low anodes, registered
//
// Build option: define BCD_SCAN_LZB_EN to blank leading zeros in the upper
// digits (the ones digit is always shown).
// -----------------------------------------------------------------------------
module bcd_scan_display
  import bcd_disp_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_in,
  input  logic [3:0]        ones_in,
  input  logic              carry_in,
  input  logic              clr,
  output logic [4*NDIG-1:0] value_bcd,
  output logic              ovf,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   an
);

  localparam int IW = $clog2(NDIG);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  // ---------------------------------------------------------------------------
  // Cascaded upper decades
  // ---------------------------------------------------------------------------
  // The ones stage wraps 9->0 in exactly the cycle en_in & carry_in is high.
  logic adv;
  assign adv = en_in & carry_in;

  // inc[k] advances decade k; inc[NDIG] is the wrap out of the top decade.
  logic [NDIG:1]   inc;
  logic [NDIG-1:1] unused_is9;   // is9 is already folded into each inc_out
  logic [3:0]      digit [NDIG];

  assign inc[1]   = adv;
  assign digit[0] = ones_in;

  for (genvar k = 1; k < NDIG; k++) begin : g_upper
    bcd_digit_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .inc     (inc[k]),
      .d       (digit[k]),
      .is9     (unused_is9[k]),
      .inc_out (inc[k+1])
    );
  end

  for (genvar k = 0; k < NDIG; k++) begin : g_value
    assign value_bcd[4*k +: 4] = digit[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (clr) begin
      ovf <= 1'b0;
    end else if (inc[NDIG]) begin
      ovf <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scanner: prescaler picks the slot length, index picks the lit digit.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] pre;
  logic [IW-1:0] idx;
  logic          scan_tick;

  assign scan_tick = (pre == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
    end else if (scan_tick) begin
      pre <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

`ifdef BCD_SCAN_LZB_EN
  // lz[k]: upper digit k and every digit above it are zero. Digit 0 never blanks.
  logic [NDIG-1:0] lz;
  logic            zero_above;

  always_comb begin
    lz         = '0;
    zero_above = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      zero_above = zero_above & (digit[i] == 4'd0);
      lz[i]      = zero_above;
    end
  end
`endif

  logic [6:0]      seg_next;
  logic [NDIG-1:0] an_next;

  // NOTE: every output of a combinational block gets a default first so no
  // path through it can leave a value held, which would infer a latch.
  always_comb begin
    an_next      = '1;
    an_next[idx] = 1'b0;
    seg_next     = bcd_to_seg(digit[idx]);
`ifdef BCD_SCAN_LZB_EN
    if (lz[idx]) begin
      seg_next = SEG_BLANK;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_BLANK;
      an  <= '1;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// -----------------------------------------------------------------------------
// tb_bcd_scan_display
// Self-checking bench for bcd_scan_display (NDIG=4, SCAN_DIV=4). A reference
// model holds the upper count as an integer, the scan slot as a cycle count
// divided by the slot length, and the display as a lookup of the lit digit.
// -----------------------------------------------------------------------------
module tb_bcd_scan_display;

  localparam int NDIG     = 4;
  localparam int SCAN_DIV = 4;
  localparam int UMAX     = 1000;   // 10**(NDIG-1)

  localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
`ifdef BCD_SCAN_LZB_EN
  localparam logic [6:0] HI_ZERO = 7'h7F;
`else
  localparam logic [6:0] HI_ZERO = 7'h40;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              en_in;
  logic [3:0]        ones_in;
  logic              carry_in;
  logic              clr;
  logic [4*NDIG-1:0] value_bcd;
  logic              ovf;
  logic [6:0]        seg;
  logic [NDIG-1:0]   an;

  bcd_scan_display #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .en_in     (en_in),
    .ones_in   (ones_in),
    .carry_in  (carry_in),
    .clr       (clr),
    .value_bcd (value_bcd),
    .ovf       (ovf),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int              m_up;
  bit              m_ovf;
  int              m_cyc;
  logic [6:0]      m_seg;
  logic [NDIG-1:0] m_an;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] code_of(input int v);
    return (v >= 0 && v <= 9) ? SEG_TAB[v] : 7'h7F;
  endfunction

  function automatic logic [4*NDIG-1:0] to_bcd(input int up, input logic [3:0] ones);
    logic [4*NDIG-1:0] r;
    r[3:0] = ones;
    for (int k = 1; k < NDIG; k++) r[4*k +: 4] = 4'((up / (10 ** (k - 1))) % 10);
    return r;
  endfunction

  task automatic model_reset();
    m_up  = 0;
    m_ovf = 0;
    m_cyc = 0;
    m_seg = 7'h7F;
    m_an  = '1;
  endtask

  // One clock: drive inputs, advance the model across the edge, check #1 later.
  task automatic cyc(input logic e, input logic [3:0] o, input logic c, input logic k);
    int              slot;
    int              dv;
    logic [6:0]      nseg;
    logic [NDIG-1:0] nan;
    en_in = e; ones_in = o; carry_in = c; clr = k;
    slot = (m_cyc / SCAN_DIV) % NDIG;
    if (slot == 0) begin
      nseg = code_of(int'(o));
    end else begin
      dv   = (m_up / (10 ** (slot - 1))) % 10;
      nseg = code_of(dv);
`ifdef BCD_SCAN_LZB_EN
      if (m_up / (10 ** (slot - 1)) == 0) nseg = 7'h7F;
`endif
    end
    nan = ~(NDIG'(1) << slot);
    @(posedge clk);
    if (k) begin
      m_up = 0; m_ovf = 0;
    end else if (e && c) begin
      if (m_up == UMAX - 1) begin m_up = 0; m_ovf = 1; end
      else m_up++;
    end
    m_cyc++;
    m_seg = nseg;
    m_an  = nan;
    #1;
    check("value_bcd", 32'(value_bcd), 32'(to_bcd(m_up, o)));
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("an", 32'(an), 32'(m_an));
    check("seg", 32'(seg), 32'(m_seg));
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'($urandom), 4'($urandom_range(0, 15)), 1'($urandom), ($urandom_range(0, 15) == 0));
  endtask

  // Asynchronous reset pulse landing between clock edges.
  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'hF);
    check("rst_upper", 32'(value_bcd[15:4]), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   q;
    logic [3:0] seen;

    rst = 1'b1; en_in = 1'b0; ones_in = 4'd0; carry_in = 1'b0; clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pulse_reset();

    // First edge after release lights digit 0 with the ones code.
    cyc(1'b0, 4'd3, 1'b0, 1'b0);
    check("first_an", 32'(an), 32'hE);
    check("first_seg", 32'(seg), 32'h30);

    rand_cycles(40);

    // Cascade 099 -> 100 in one edge; carry without enable holds.
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    repeat (99) cyc(1'b1, 4'd9, 1'b1, 1'b0);
    check("upper_099", 32'(value_bcd[15:4]), 32'h099);
    cyc(1'b1, 4'd9, 1'b1, 1'b0);
    check("upper_100", 32'(value_bcd[15:4]), 32'h100);
    repeat (3) cyc(1'b0, 4'd9, 1'b1, 1'b0);
    check("no_en_hold", 32'(value_bcd[15:4]), 32'h100);

    // Overflow: 999 + adv -> 000 with sticky ovf.
    repeat (899) cyc(1'b1, 4'd9, 1'b1, 1'b0);
    check("upper_999", 32'(value_bcd[15:4]), 32'h999);
    check("ovf_before", 32'(ovf), 32'h0);
    cyc(1'b1, 4'd9, 1'b1, 1'b0);
    check("upper_wrap", 32'(value_bcd[15:4]), 32'h000);
    check("ovf_set", 32'(ovf), 32'h1);
    repeat (20) cyc(1'b0, 4'($urandom_range(0, 9)), 1'($urandom), 1'b0);
    check("ovf_held", 32'(ovf), 32'h1);

    // clr beats a simultaneous advance.
    cyc(1'b1, 4'd9, 1'b1, 1'b1);
    check("clr_upper", 32'(value_bcd[15:4]), 32'h000);
    check("clr_ovf", 32'(ovf), 32'h0);

    // Non-decimal ones digit shows blank across a full scan.
    repeat (16) cyc(1'b0, 4'hB, 1'b0, 1'b0);

    // Chain with a decade-stage model: 1000 counts -> 1000.
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    q = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc(1'b1, 4'(q), (q == 9), 1'b0);
      q = (q + 1) % 10;
    end
    ones_in = 4'(q); carry_in = 1'b0; en_in = 1'b0;
    #1;
    check("chain_1000", 32'(value_bcd), 32'h1000);
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 4'(q), (q == 9), 1'b0);
      q = (q + 1) % 10;
    end
    repeat (20) cyc(1'b0, 4'(q), (q == 9), 1'b0);
    check("chain_frozen", 32'(value_bcd), 32'h1009);

    // Leading zeros: value 0050.
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    repeat (5) cyc(1'b1, 4'd9, 1'b1, 1'b0);
    seen = '0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 4'd0, 1'b0, 1'b0);
      case (an)
        4'h7: begin check("lzb_slot3", 32'(seg), 32'(HI_ZERO)); seen[3] = 1'b1; end
        4'hB: begin check("lzb_slot2", 32'(seg), 32'(HI_ZERO)); seen[2] = 1'b1; end
        4'hD: begin check("lzb_slot1", 32'(seg), 32'h12);       seen[1] = 1'b1; end
        4'hE: begin check("lzb_slot0", 32'(seg), 32'h40);       seen[0] = 1'b1; end
        default: ;
      endcase
    end
    check("lzb_all_slots", 32'(seen), 32'hF);

    // Reset mid-run, then random traffic again.
    rand_cycles(10);
    pulse_reset();
    cyc(1'b0, 4'd7, 1'b0, 1'b0);
    check("rerst_an", 32'(an), 32'hE);
    check("rerst_seg", 32'(seg), 32'h78);
    rand_cycles(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
